// File: rtl/decode_issue_unit.sv
// Dual-issue decode stage: decodes the fetched pair, splits it over two cycles on an
// intra-pair hazard, and drives two registered issue slots (slot0 always oldest).
module decode_issue_unit #(
  parameter bit          SPLIT_ON_BRANCH = 1'b1,
  parameter int unsigned IW              = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          stall_in,
  input  logic [IW-1:0] instr1,
  input  logic [IW-1:0] instr2,
  output logic          fetch_stall,
  output logic          s0_valid,
  output logic [3:0]    s0_op,
  output logic [2:0]    s0_rd,
  output logic [2:0]    s0_rs1,
  output logic [2:0]    s0_rs2,
  output logic [15:0]   s0_imm,
  output logic          s0_we,
  output logic          s0_ld,
  output logic          s0_st,
  output logic          s0_br,
  output logic          s0_ill,
  output logic          s1_valid,
  output logic [3:0]    s1_op,
  output logic [2:0]    s1_rd,
  output logic [2:0]    s1_rs1,
  output logic [2:0]    s1_rs2,
  output logic [15:0]   s1_imm,
  output logic          s1_we,
  output logic          s1_ld,
  output logic          s1_st,
  output logic          s1_br,
  output logic          s1_ill
);

  localparam logic [0:0] StPass  = 1'b0;
  localparam logic [0:0] StSplit = 1'b1;

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [15:0] imm;
    logic        we;
    logic        ld;
    logic        st;
    logic        br;
    logic        ill;
  } uop_t;

  // Unused fields stay 0 so the hazard compares below need no per-format qualification.
  function automatic uop_t decode(input logic [IW-1:0] ins);
    uop_t u;
    u = '0;
    if (ins != '0) begin
      u.valid = 1'b1;
      u.op    = ins[15:12];
      case (ins[15:12])
        4'h0: ;
        4'h1, 4'h2, 4'h3, 4'h4: begin
          u.rd  = ins[11:9];
          u.rs1 = ins[8:6];
          u.rs2 = ins[5:3];
        end
        4'h5, 4'h6: begin
          u.rd  = ins[11:9];
          u.rs1 = ins[8:6];
          u.imm = {{10{ins[5]}}, ins[5:0]};
          u.ld  = (ins[15:12] == 4'h6);
        end
        4'h7: begin
          u.rs2 = ins[11:9];
          u.rs1 = ins[8:6];
          u.imm = {{10{ins[5]}}, ins[5:0]};
          u.st  = 1'b1;
        end
        4'h8: begin
          u.rs1 = ins[11:9];
          u.rs2 = ins[8:6];
          u.imm = {{10{ins[5]}}, ins[5:0]};
          u.br  = 1'b1;
        end
        4'h9: begin
          u.imm = {{4{ins[11]}}, ins[11:0]};
          u.br  = 1'b1;
        end
        default: u.ill = 1'b1;
      endcase
      u.we = (u.rd != 3'd0);
    end
    return u;
  endfunction

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] hold_q, hold_d;
  uop_t          slot0_q, slot0_d, slot1_q, slot1_d;
  uop_t          dec1, dec2;
  logic          raw, waw, mem_pair, br_split, split;

  always_comb begin
    dec1     = decode(instr1);
    dec2     = decode(instr2);
    raw      = dec1.we && ((dec2.rs1 == dec1.rd) || (dec2.rs2 == dec1.rd));
    waw      = dec1.we && dec2.we && (dec1.rd == dec2.rd);
    mem_pair = (dec1.ld || dec1.st) && (dec2.ld || dec2.st);
    br_split = SPLIT_ON_BRANCH && dec1.br;
    split    = dec1.valid && dec2.valid && (raw || waw || mem_pair || br_split);
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (flush) begin
      state_d = StPass;
      hold_d  = '0;
      slot0_d = '0;
      slot1_d = '0;
    end else if (!stall_in) begin
      if (state_q == StSplit) begin
        // Inputs are ignored here; fetch re-presents the next pair once fetch_stall drops.
        slot0_d = decode(hold_q);
        slot1_d = '0;
        hold_d  = '0;
        state_d = StPass;
      end else if (split) begin
        slot0_d = dec1;
        slot1_d = '0;
        hold_d  = instr2;
        state_d = StSplit;
      end else if (!dec1.valid) begin
        slot0_d = dec2;
        slot1_d = '0;
      end else begin
        slot0_d = dec1;
        slot1_d = dec2;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StPass;
      hold_q  <= '0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  assign fetch_stall = (state_q == StSplit) || stall_in;

  assign s0_valid = slot0_q.valid;
  assign s0_op    = slot0_q.op;
  assign s0_rd    = slot0_q.rd;
  assign s0_rs1   = slot0_q.rs1;
  assign s0_rs2   = slot0_q.rs2;
  assign s0_imm   = slot0_q.imm;
  assign s0_we    = slot0_q.we;
  assign s0_ld    = slot0_q.ld;
  assign s0_st    = slot0_q.st;
  assign s0_br    = slot0_q.br;
  assign s0_ill   = slot0_q.ill;

  assign s1_valid = slot1_q.valid;
  assign s1_op    = slot1_q.op;
  assign s1_rd    = slot1_q.rd;
  assign s1_rs1   = slot1_q.rs1;
  assign s1_rs2   = slot1_q.rs2;
  assign s1_imm   = slot1_q.imm;
  assign s1_we    = slot1_q.we;
  assign s1_ld    = slot1_q.ld;
  assign s1_st    = slot1_q.st;
  assign s1_br    = slot1_q.br;
  assign s1_ill   = slot1_q.ill;

endmodule
